oled_spi_writer: RTL and testbench

Byte-level transmit stage between the OLED command/text sequencers and the display's SPI pins. It accepts bytes with a data/command flag through a single-cycle write strobe and buffers them in a small FIFO. It serialises each byte MSB-first in SPI mode 0, with chip-select framing per byte and a matching D/C line. Upstream sequencers throttle on `buffer_full`; the power and reset pins (`oled_res`, `oled_vbat`, `oled_vdd`) are driven by a separate block.

---
 rtl/oled_pkg.sv | 18 +
 rtl/oled_byte_fifo.sv | 67 ++++++
 rtl/oled_spi_writer.sv | 148 ++++++++++++++
 tb/tb_oled_spi_writer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI transmit path: serialiser state encoding,
// byte geometry, D/C flag values and default block parameters.
package oled_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } oled_state_e;

  localparam int   OLED_BYTE_BITS      = 8;
  localparam logic OLED_DC_CMD         = 1'b0;
  localparam logic OLED_DC_DATA        = 1'b1;
  localparam int   OLED_CLK_DIV_DEF    = 4;
  localparam int   OLED_FIFO_DEPTH_DEF = 8;

endpackage

// File: rtl/oled_byte_fifo.sv
// Synchronous FIFO holding {dc, byte} entries; full/empty are registered from
// the next occupancy so they describe the FIFO at the start of each cycle.
module oled_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A push into a full FIFO is refused even when a pop frees a slot this cycle.
  assign w_push_ok = i_push && !r_full;
  assign w_pop_ok  = i_pop && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/oled_spi_writer.sv
// Buffered byte transmitter for the OLED panel: SPI mode 0, MSB first, chip
// select framed per byte with the D/C line held for the byte in flight.
module oled_spi_writer
  import oled_pkg::*;
#(
  parameter int CLK_DIV    = OLED_CLK_DIV_DEF,
  parameter int FIFO_DEPTH = OLED_FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       dc_in,
  input  logic       write_enable,
  output logic       buffer_full,
  output logic       buffer_empty,
  output logic       busy,
  output logic       overflow,
  output logic       spi_cs,
  output logic       spi_clk,
  output logic       spi_mosi,
  output logic       oled_dc
);

  localparam int               CNT_W    = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  oled_state_e r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_dc, w_dc_nxt;
  logic             r_cs, w_cs_nxt;
  logic             r_sclk, w_sclk_nxt;
  logic             r_overflow;
  logic             w_pop;
  logic             w_cnt_end;
  logic [8:0]       w_fifo_data;
  logic             w_full;
  logic             w_empty;

  oled_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (write_enable),
    .i_pop   (w_pop),
    .i_data  ({dc_in, data_in}),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_cnt_end = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_dc_nxt    = r_dc;
    w_cs_nxt    = r_cs;
    w_sclk_nxt  = r_sclk;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_data[7:0];
          w_dc_nxt    = w_fifo_data[8];
          w_cs_nxt    = 1'b0;
          w_sclk_nxt  = 1'b0;
          w_bit_nxt   = 3'(OLED_BYTE_BITS - 1);
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_cnt_end) begin
          w_cnt_nxt  = '0;
          w_sclk_nxt = !r_sclk;
          // MOSI advances on the falling SCLK edge, except after the last bit.
          if (r_sclk) begin
            if (r_bit == 3'd0) begin
              w_state_nxt = ST_HOLD;
            end else begin
              w_bit_nxt   = r_bit - 3'd1;
              w_shift_nxt = {r_shift[6:0], 1'b0};
            end
          end
        end
      end
      ST_HOLD: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_cnt_end) begin
          w_cnt_nxt   = '0;
          w_cs_nxt    = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_cnt_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_dc    <= OLED_DC_CMD;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_dc    <= w_dc_nxt;
      r_cs    <= w_cs_nxt;
      r_sclk  <= w_sclk_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_overflow <= 1'b0;
    else if (write_enable && w_full)   r_overflow <= 1'b1;
  end

  assign buffer_full  = w_full;
  assign buffer_empty = w_empty;
  assign busy         = !w_empty || (r_state != ST_IDLE);
  assign overflow     = r_overflow;
  assign spi_cs       = r_cs;
  assign spi_clk      = r_sclk;
  assign spi_mosi     = r_shift[7];
  assign oled_dc      = r_dc;

endmodule

// File: tb/tb_oled_spi_writer.sv
// Directed bench for oled_spi_writer: a default instance (CLK_DIV=4) and a
// fast instance (CLK_DIV=1), each watched by a negedge SPI frame decoder.
`timescale 1ns/1ps
module tb_oled_spi_writer;
  import oled_pkg::*;

  localparam int DIV  = 4;
  localparam int DIV1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic dc_in = 1'b0;
  logic we = 1'b0;
  logic full, empty, busy, ovf, cs, sck, mosi, dc;
  logic [7:0] data1 = '0;
  logic dc1_in = 1'b0;
  logic we1 = 1'b0;
  logic full1, empty1, busy1, ovf1, cs1, sck1, mosi1, dc1;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  oled_spi_writer #(.CLK_DIV(DIV), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dc_in(dc_in), .write_enable(we),
    .buffer_full(full), .buffer_empty(empty), .busy(busy), .overflow(ovf),
    .spi_cs(cs), .spi_clk(sck), .spi_mosi(mosi), .oled_dc(dc));

  oled_spi_writer #(.CLK_DIV(DIV1), .FIFO_DEPTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data1), .dc_in(dc1_in), .write_enable(we1),
    .buffer_full(full1), .buffer_empty(empty1), .busy(busy1), .overflow(ovf1),
    .spi_cs(cs1), .spi_clk(sck1), .spi_mosi(mosi1), .oled_dc(dc1));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [8:0] rxat(input logic [8:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  // Frame decoder for the CLK_DIV=4 instance
  int fall_q[$], rise_q[$], sck_q[$], bits_q[$], busyfall_q[$], full_q[$], ovf_q[$];
  logic [8:0] rx_q[$];
  logic m_pcs = 1'b1, m_psck = 1'b0, m_pbusy = 1'b0, m_pfull = 1'b0, m_povf = 1'b0;
  logic [7:0] m_sh = '0;
  logic m_dc = 1'b0;
  int m_bits = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_pcs = 1'b1; m_psck = 1'b0; m_pbusy = 1'b0; m_pfull = 1'b0; m_povf = 1'b0; m_bits = 0;
    end else begin
      if (m_pcs && !cs) begin fall_q.push_back(cyc); m_bits = 0; m_sh = '0; m_dc = dc; end
      if (!m_psck && sck && !cs) begin
        if (m_bits == 0) sck_q.push_back(cyc);
        m_sh = {m_sh[6:0], mosi};
        m_bits++;
      end
      if (!m_pcs && cs) begin rise_q.push_back(cyc); rx_q.push_back({m_dc, m_sh}); bits_q.push_back(m_bits); end
      if (m_pbusy && !busy) busyfall_q.push_back(cyc);
      if (!m_pfull && full) full_q.push_back(cyc);
      if (!m_povf && ovf) ovf_q.push_back(cyc);
      m_pcs = cs; m_psck = sck; m_pbusy = busy; m_pfull = full; m_povf = ovf;
    end
  end

  // Frame decoder for the CLK_DIV=1 instance, also flags D/C moving inside a frame
  int fall1_q[$], rise1_q[$];
  logic [8:0] rx1_q[$];
  logic m1_pcs = 1'b1, m1_psck = 1'b0, m1_pdc = 1'b0, m1_dc = 1'b0;
  logic [7:0] m1_sh = '0;
  int dc1_viol = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m1_pcs = 1'b1; m1_psck = 1'b0; m1_pdc = 1'b0;
    end else begin
      if (dc1 !== m1_pdc && !m1_pcs) dc1_viol++;
      if (m1_pcs && !cs1) begin fall1_q.push_back(cyc); m1_sh = '0; m1_dc = dc1; end
      if (!m1_psck && sck1 && !cs1) m1_sh = {m1_sh[6:0], mosi1};
      if (!m1_pcs && cs1) begin rise1_q.push_back(cyc); rx1_q.push_back({m1_dc, m1_sh}); end
      m1_pcs = cs1; m1_psck = sck1; m1_pdc = dc1;
    end
  end

  task automatic clear_q();
    fall_q.delete(); rise_q.delete(); sck_q.delete(); bits_q.delete();
    busyfall_q.delete(); full_q.delete(); ovf_q.delete(); rx_q.delete();
    fall1_q.delete(); rise1_q.delete(); rx1_q.delete(); dc1_viol = 0;
  endtask

  task automatic push0(input logic [7:0] d, input logic f);
    data_in = d; dc_in = f; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic push1(input logic [7:0] d, input logic f);
    data1 = d; dc1_in = f; we1 = 1'b1;
    @(posedge clk); #1;
    we1 = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit which, input int bound);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
      if (which == 1'b0 && !busy && empty) done = 1'b1;
      if (which == 1'b1 && !busy1 && empty1) done = 1'b1;
    end
    check_eq(tag, 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic [7:0] hello [5];
    hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs", 32'(cs), 32'd1);
    check_eq("rst_sck", 32'(sck), 32'd0);
    check_eq("rst_mosi", 32'(mosi), 32'd0);
    check_eq("rst_dc", 32'(dc), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single byte 0xA5 as display data
    clear_q();
    while (cyc < 10) begin @(posedge clk); #1; end
    p = cyc;
    push0(8'hA5, OLED_DC_DATA);
    @(negedge clk);
    check_eq("a5_empty_p1", 32'(empty), 32'd0);
    wait_idle("a5_idle", 1'b0, 300);
    check_eq("a5_frames", fall_q.size(), 1);
    check_eq("a5_cs_fall", qat(fall_q, 0), p + 2);
    check_eq("a5_first_rise", qat(sck_q, 0), p + 2 + DIV);
    check_eq("a5_byte", 32'(rxat(rx_q, 0)), 32'h1A5);
    check_eq("a5_bits", qat(bits_q, 0), 8);
    check_eq("a5_cs_low", qat(rise_q, 0) - qat(fall_q, 0), 17 * DIV);

    // "hello" back to back
    clear_q();
    for (int i = 0; i < 5; i++) push0(hello[i], OLED_DC_DATA);
    wait_idle("hello_idle", 1'b0, 600);
    check_eq("hello_count", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) check_eq($sformatf("hello_byte%0d", i), 32'(rxat(rx_q, i)), {23'd0, 1'b1, hello[i]});
    for (int i = 1; i < 5; i++) check_eq($sformatf("hello_period%0d", i), qat(fall_q, i) - qat(fall_q, i - 1), 1 + 18 * DIV);
    check_eq("hello_busy_fall", qat(busyfall_q, 0), qat(rise_q, 4) + DIV);

    // Ten pushes into an 8-deep FIFO: the tenth is dropped
    clear_q();
    p = cyc;
    for (int i = 0; i < 10; i++) push0(8'h10 + 8'(i), 1'(i & 1));
    wait_idle("ovf_idle", 1'b0, 1500);
    check_eq("ovf_full_rise", qat(full_q, 0), p + 9);
    check_eq("ovf_set_cycle", qat(ovf_q, 0), p + 10);
    check_eq("ovf_sticky", 32'(ovf), 32'd1);
    check_eq("ovf_tx_count", rx_q.size(), 9);
    for (int i = 0; i < 9; i++) check_eq($sformatf("ovf_byte%0d", i), 32'(rxat(rx_q, i)), 32'({1'(i & 1), 8'h10 + 8'(i)}));

    // Push in the same cycle as the pop of a single entry
    clear_q();
    push0(8'h3A, OLED_DC_CMD);
    push0(8'hC5, OLED_DC_DATA);
    @(negedge clk);
    check_eq("pp_empty", 32'(empty), 32'd0);
    check_eq("pp_full", 32'(full), 32'd0);
    wait_idle("pp_idle", 1'b0, 400);
    check_eq("pp_count", rx_q.size(), 2);
    check_eq("pp_byte0", 32'(rxat(rx_q, 0)), 32'h03A);
    check_eq("pp_byte1", 32'(rxat(rx_q, 1)), 32'h1C5);
    check_eq("pp_period", qat(fall_q, 1) - qat(fall_q, 0), 1 + 18 * DIV);

    // Reset during the SCLK-high phase of bit 3 with a second byte queued
    clear_q();
    p = cyc;
    push0(8'h3C, OLED_DC_CMD);
    push0(8'h99, OLED_DC_DATA);
    while (cyc < p + 2 + 9 * DIV) begin @(posedge clk); #1; end
    check_eq("mid_sck_high", 32'(sck), 32'd1);
    check_eq("mid_cs_low", 32'(cs), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cs", 32'(cs), 32'd1);
    check_eq("mid_rst_sck", 32'(sck), 32'd0);
    check_eq("mid_rst_mosi", 32'(mosi), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
    repeat (200) @(posedge clk);
    #1;
    check_eq("mid_no_frames", fall_q.size(), 0);
    check_eq("mid_no_rx", rx_q.size(), 0);
    check_eq("mid_empty", 32'(empty), 32'd1);
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_ovf_cleared", 32'(ovf), 32'd0);

    // CLK_DIV=1: command 0x00 then data 0xFF
    clear_q();
    p = cyc;
    push1(8'h00, OLED_DC_CMD);
    push1(8'hFF, OLED_DC_DATA);
    wait_idle("div1_idle", 1'b1, 200);
    check_eq("div1_count", rx1_q.size(), 2);
    check_eq("div1_byte0", 32'(rxat(rx1_q, 0)), 32'h000);
    check_eq("div1_byte1", 32'(rxat(rx1_q, 1)), 32'h1FF);
    check_eq("div1_cs_fall", qat(fall1_q, 0), p + 2);
    check_eq("div1_period", qat(fall1_q, 1) - qat(fall1_q, 0), 1 + 18 * DIV1);
    check_eq("div1_cs_low", qat(rise1_q, 0) - qat(fall1_q, 0), 17 * DIV1);
    check_eq("div1_dc_in_frame", dc1_viol, 0);
    check_eq("div1_dc_final", 32'(dc1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
